dcache_flush_unit: RTL and testbench
====================================

# dcache_flush_unit

Write-back data-cache flush engine: the responder for the flush controller's `flush_dcache` / `flush_dcache_ack` handshake. On a flush request it takes exclusive access to the tag/status array and walks every set. For each set it writes back every valid-dirty way, then invalidates the whole set, and finally returns a single-cycle acknowledge. It sits inside the write-back dcache, between the flush controller, the tag/status array arbiter and the miss/write-back unit.

## Interface
Parameters:
- NR_SETS, 256, number of sets; power of two, ≥2; IDX_W = $clog2(NR_SETS)
- NR_WAYS, 8, ways per set, ≥1; WAY_W = max(1, $clog2(NR_WAYS))
- TAG_W, 44, tag width
- OFFSET_W, 4, line byte-offset width; ADDR_W = TAG_W + IDX_W + OFFSET_W

Ports:
- clk_i  in  1  clock; all logic on its rising edge
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  flush request level from the flush controller (registered on the controller side)
- flush_ack_o  out  1  one-cycle pulse; the flush is complete
- busy_o  out  1  engine owns the array; stalls load/store/miss traffic
- arr_gnt_i  in  1  arbiter grant; once given, the arbiter holds it high while busy_o=1
- tag_req_o  out  1  read all ways of set tag_idx_o; data returns next cycle
- tag_idx_o  out  IDX_W  set index being walked
- tag_valid_i  in  NR_WAYS  per-way valid bit (1-cycle read latency)
- tag_dirty_i  in  NR_WAYS  per-way dirty bit
- tag_i  in  NR_WAYS*TAG_W  per-way tag; way w occupies bits [w*TAG_W +: TAG_W]
- wb_valid_o  out  1  write-back request valid
- wb_ready_i  in  1  write-back unit accepts the request
- wb_addr_o  out  ADDR_W  line address {tag, idx, OFFSET_W'b0}
- wb_way_o  out  WAY_W  way to read the line data from
- wb_done_i  in  1  pulse: the accepted write-back has finished
- inv_we_o  out  1  clear valid and dirty for all ways of set tag_idx_o

## Operation
- States: IDLE, ARB, READ, LOOKUP, WB_REQ, WB_WAIT, INV, DONE, WAIT_LOW.
- IDLE: if flush_i=1, clear the set counter to 0 and go to ARB.
- ARB: busy_o=1. Go to READ once arr_gnt_i=1.
- READ: tag_req_o=1 for one cycle at the current index. Go to LOOKUP.
- LOOKUP:
  - Capture the pending vector = tag_valid_i & tag_dirty_i, and capture all tags.
  - If pending ≠ 0, go to WB_REQ; otherwise go to INV.
  - Valid-clean and invalid lines are never written back.
- WB_REQ:
  - Select the lowest-index pending way. Hold wb_valid_o=1 with a stable wb_addr_o and wb_way_o until wb_ready_i=1.
  - On the handshake, go to WB_WAIT.
- WB_WAIT:
  - On wb_done_i=1, clear that way's pending bit.
  - Then go to WB_REQ if bits remain, otherwise to INV.
  - wb_done_i in any other state is ignored.
- INV: inv_we_o=1 for one cycle.
  - If the index is NR_SETS-1, go to DONE.
  - Otherwise increment the index (IDX_W bits, no wrap beyond the last set) and go to READ.
- DONE: flush_ack_o=1 for exactly one cycle. Go to WAIT_LOW.
- WAIT_LOW: busy_o=0. Return to IDLE once flush_i=0.
  - The controller's request is registered, so flush_i is still high the cycle after the ack. That high level must not start a second flush.
- A flush_i drop mid-walk is ignored; the walk always completes and is acknowledged.
- busy_o=1 in ARB, READ, LOOKUP, WB_REQ, WB_WAIT, INV and DONE; 0 in IDLE and WAIT_LOW.
- Reset, at any time including mid-walk: state=IDLE, index=0, pending=0. All outputs are 0: flush_ack_o, busy_o, tag_req_o, tag_idx_o, wb_valid_o, wb_addr_o, wb_way_o, inv_we_o. No ack is ever issued for an interrupted walk.

## Timing
- flush_ack_o, busy_o, tag_req_o, wb_valid_o and inv_we_o are decoded from registered state only, with no combinational path from inputs.
- Clean-cache latency with arr_gnt_i already high:
  - flush_i sampled high in IDLE at cycle 0.
  - ARB at cycle 1.
  - Set s: READ at 2+3s, LOOKUP at 3+3s, INV at 4+3s.
  - flush_ack_o at cycle 3·NR_SETS+2.
- Each dirty way adds 2 cycles plus the write-back unit's ready and done latency.
- Each cycle arr_gnt_i is low in ARB adds 1 cycle.
- tag_idx_o changes only on leaving INV, and is stable from READ through INV of a set.
- wb_valid_o never deasserts before wb_ready_i. At most one write-back is outstanding.

## Test plan
- Clean cache, NR_SETS=4, NR_WAYS=2, gnt tied high, flush_i rises at cycle 0:
  - flush_ack_o pulses only at cycle 14.
  - inv_we_o fires at cycles 4, 7, 10, 13 with idx 0..3.
  - wb_valid_o is never asserted.
- Set 2 has both ways valid-dirty, tags 0x5 and 0x9 (OFFSET_W=4, IDX_W=2), wb_ready_i and wb_done_i each respond 1 cycle later:
  - Write-backs go out in order way0 at addr 0x160, then way1 at addr 0x260.
  - inv_we_o for set 2 fires only after the second wb_done_i.
- Valid-clean line plus invalid-dirty line in set 1 -> no write-back; set 1 is invalidated; ack latency is the same as the clean case.
- Controller handshake: flush_i is held high one cycle past the ack, then dropped.
  - Exactly one flush_ack_o pulse.
  - busy_o falls the cycle after the ack.
  - No second walk starts.
  - A new flush_i rise later restarts the walk at idx 0.
- arr_gnt_i held low for 5 cycles -> busy_o=1 and tag_req_o=0 throughout; the walk starts on the grant; ack is delayed by 5 cycles.
- rst_i asserted while in WB_WAIT of set 1:
  - All outputs go to 0 immediately.
  - No ack is issued.
  - After release, the next flush restarts at idx 0.

Source files
------------

// File: rtl/dcache_flush_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dcache_flush_unit: walks every set, writes back valid-dirty ways, then
// invalidates the set; one-cycle ack when the whole array is clean.
// Revision: 1.0
// ----------------------------------------------------------------------------
module dcache_flush_unit #(
  parameter int NR_SETS  = 256,
  parameter int NR_WAYS  = 8,
  parameter int TAG_W    = 44,
  parameter int OFFSET_W = 4,
  localparam int IDX_W   = $clog2(NR_SETS),
  localparam int WAY_W   = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1,
  localparam int ADDR_W  = TAG_W + IDX_W + OFFSET_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  output logic                     flush_ack_o,
  output logic                     busy_o,
  input  logic                     arr_gnt_i,
  output logic                     tag_req_o,
  output logic [IDX_W-1:0]         tag_idx_o,
  input  logic [NR_WAYS-1:0]       tag_valid_i,
  input  logic [NR_WAYS-1:0]       tag_dirty_i,
  input  logic [NR_WAYS*TAG_W-1:0] tag_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [ADDR_W-1:0]        wb_addr_o,
  output logic [WAY_W-1:0]         wb_way_o,
  input  logic                     wb_done_i,
  output logic                     inv_we_o
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NR_SETS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_READ, S_LOOKUP, S_WB_REQ, S_WB_WAIT, S_INV, S_DONE, S_WAIT_LOW
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NR_WAYS-1:0]       pend_q, pend_d;
  logic [NR_WAYS*TAG_W-1:0] tags_q, tags_d;
  logic [WAY_W-1:0]         sel_way;
  logic [TAG_W-1:0]         sel_tag;

  logic                     busy_q, tag_req_q, wb_valid_q, inv_we_q, ack_q;
  logic [ADDR_W-1:0]        wb_addr_q;
  logic [WAY_W-1:0]         wb_way_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    tags_d  = tags_q;
    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          idx_d   = '0;
          state_d = S_ARB;
        end
      end
      S_ARB:    if (arr_gnt_i) state_d = S_READ;
      S_READ:   state_d = S_LOOKUP;
      S_LOOKUP: begin
        pend_d  = tag_valid_i & tag_dirty_i;
        tags_d  = tag_i;
        state_d = (pend_d != '0) ? S_WB_REQ : S_INV;
      end
      S_WB_REQ: if (wb_ready_i) state_d = S_WB_WAIT;
      S_WB_WAIT: begin
        if (wb_done_i) begin
          for (int w = 0; w < NR_WAYS; w++) begin
            if (WAY_W'(w) == wb_way_q) pend_d[w] = 1'b0;
          end
          state_d = (pend_d == '0) ? S_INV : S_WB_REQ;
        end
      end
      S_INV: begin
        if (idx_q == c_last_idx) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_READ;
        end
      end
      S_DONE:     state_d = S_WAIT_LOW;
      // The controller's request is still high right after the ack.
      S_WAIT_LOW: if (!flush_i) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Lowest-index pending way wins; evaluated on the next-state vector so the
  // registered request is ready on the first WB_REQ cycle.
  always_comb begin
    sel_way = '0;
    sel_tag = '0;
    for (int w = NR_WAYS - 1; w >= 0; w--) begin
      if (pend_d[w]) begin
        sel_way = WAY_W'(w);
        sel_tag = tags_d[w*TAG_W +: TAG_W];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      pend_q     <= '0;
      tags_q     <= '0;
      busy_q     <= 1'b0;
      tag_req_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      inv_we_q   <= 1'b0;
      ack_q      <= 1'b0;
      wb_addr_q  <= '0;
      wb_way_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      tags_q     <= tags_d;
      busy_q     <= (state_d != S_IDLE) && (state_d != S_WAIT_LOW);
      tag_req_q  <= (state_d == S_READ);
      wb_valid_q <= (state_d == S_WB_REQ);
      inv_we_q   <= (state_d == S_INV);
      ack_q      <= (state_d == S_DONE);
      if (state_d == S_WB_REQ) begin
        wb_addr_q <= {sel_tag, idx_d, {OFFSET_W{1'b0}}};
        wb_way_q  <= sel_way;
      end
    end
  end

  assign flush_ack_o = ack_q;
  assign busy_o      = busy_q;
  assign tag_req_o   = tag_req_q;
  assign tag_idx_o   = idx_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_addr_o   = wb_addr_q;
  assign wb_way_o    = wb_way_q;
  assign inv_we_o    = inv_we_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_flush_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dcache_flush_unit: directed flush scenarios against a cycle schedule
// derived from the walk/latency rules. Revision: 1.0
// ----------------------------------------------------------------------------
module tb_dcache_flush_unit;

  localparam int NR_SETS  = 4;
  localparam int NR_WAYS  = 2;
  localparam int TAG_W    = 8;
  localparam int OFFSET_W = 4;
  localparam int IDX_W    = 2;
  localparam int WAY_W    = 1;
  localparam int ADDR_W   = TAG_W + IDX_W + OFFSET_W;
  localparam int SMAX     = 128;
  localparam int WB_R     = 1;
  localparam int WB_D     = 1;

  logic                     clk_i;
  logic                     rst_i;
  logic                     flush_i;
  logic                     flush_ack_o;
  logic                     busy_o;
  logic                     arr_gnt_i;
  logic                     tag_req_o;
  logic [IDX_W-1:0]         tag_idx_o;
  logic [NR_WAYS-1:0]       tag_valid_i;
  logic [NR_WAYS-1:0]       tag_dirty_i;
  logic [NR_WAYS*TAG_W-1:0] tag_i;
  logic                     wb_valid_o;
  logic                     wb_ready_i;
  logic [ADDR_W-1:0]        wb_addr_o;
  logic [WAY_W-1:0]         wb_way_o;
  logic                     wb_done_i;
  logic                     inv_we_o;

  dcache_flush_unit #(
    .NR_SETS(NR_SETS), .NR_WAYS(NR_WAYS), .TAG_W(TAG_W), .OFFSET_W(OFFSET_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .flush_ack_o(flush_ack_o),
    .busy_o(busy_o), .arr_gnt_i(arr_gnt_i), .tag_req_o(tag_req_o),
    .tag_idx_o(tag_idx_o), .tag_valid_i(tag_valid_i), .tag_dirty_i(tag_dirty_i),
    .tag_i(tag_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_addr_o(wb_addr_o), .wb_way_o(wb_way_o), .wb_done_i(wb_done_i),
    .inv_we_o(inv_we_o)
  );

  typedef struct packed {
    logic              busy;
    logic              req;
    logic              wbv;
    logic              inv;
    logic              ack;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] addr;
    logic [WAY_W-1:0]  way;
  } exp_t;

  exp_t              sched [SMAX];
  int                slen, ack_k, start, cyc;
  bit                win;
  int                tests, fails, acks;
  int                invq [$];
  logic [ADDR_W-1:0] wbq [$];

  logic [NR_WAYS-1:0] av [NR_SETS];
  logic [NR_WAYS-1:0] ad [NR_SETS];
  logic [TAG_W-1:0]   at [NR_SETS][NR_WAYS];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc - start, act, exp);
    end
  endtask

  // Expected outputs per cycle of a walk, cycle 0 being the one where flush_i
  // is first seen high in IDLE; g = grant-low cycles, r/d = ready/done delay.
  task automatic build(input int g, input int r, input int d);
    int t;
    for (int i = 0; i < SMAX; i++) sched[i] = '0;
    t = 1;
    for (int i = 0; i <= g; i++) begin
      sched[t].busy = 1'b1;
      t++;
    end
    for (int s = 0; s < NR_SETS; s++) begin
      sched[t].busy = 1'b1; sched[t].req = 1'b1; sched[t].idx = IDX_W'(s); t++;
      sched[t].busy = 1'b1; sched[t].idx = IDX_W'(s); t++;
      for (int w = 0; w < NR_WAYS; w++) begin
        if (av[s][w] && ad[s][w]) begin
          for (int i = 0; i <= r; i++) begin
            sched[t].busy = 1'b1;
            sched[t].wbv  = 1'b1;
            sched[t].idx  = IDX_W'(s);
            sched[t].addr = ADDR_W'((int'(at[s][w]) * NR_SETS + s) * (1 << OFFSET_W));
            sched[t].way  = WAY_W'(w);
            t++;
          end
          for (int i = 0; i <= d; i++) begin
            sched[t].busy = 1'b1; sched[t].idx = IDX_W'(s); t++;
          end
        end
      end
      sched[t].busy = 1'b1; sched[t].inv = 1'b1; sched[t].idx = IDX_W'(s); t++;
    end
    ack_k = t;
    sched[t].busy = 1'b1; sched[t].ack = 1'b1; sched[t].idx = IDX_W'(NR_SETS - 1);
    slen = t + 2;
  endtask

  always @(negedge clk_i) begin : p_cmp
    exp_t e;
    int   k;
    e = '0;
    k = cyc - start;
    if (win && k >= 0 && k < slen) e = sched[k];
    check("busy_o",      32'(busy_o),      32'(e.busy));
    check("tag_req_o",   32'(tag_req_o),   32'(e.req));
    check("wb_valid_o",  32'(wb_valid_o),  32'(e.wbv));
    check("inv_we_o",    32'(inv_we_o),    32'(e.inv));
    check("flush_ack_o", 32'(flush_ack_o), 32'(e.ack));
    if (e.busy) check("tag_idx_o", 32'(tag_idx_o), 32'(e.idx));
    if (e.wbv) begin
      check("wb_addr_o", 32'(wb_addr_o), 32'(e.addr));
      check("wb_way_o",  32'(wb_way_o),  32'(e.way));
    end
    if (flush_ack_o) acks++;
    if (win && inv_we_o) invq.push_back(k);
  end

  // Tag/status array: one-cycle read latency, invalidate on inv_we_o.
  logic             prev_req, prev_inv;
  logic [IDX_W-1:0] prev_idx;
  always @(posedge clk_i) begin : p_tags
    #1;
    if (rst_i) begin
      prev_req = 1'b0; prev_inv = 1'b0; prev_idx = '0;
      tag_valid_i = '1; tag_dirty_i = '1; tag_i = '1;
    end else begin
      if (prev_inv) begin
        av[prev_idx] = '0;
        ad[prev_idx] = '0;
      end
      if (prev_req) begin
        tag_valid_i = av[prev_idx];
        tag_dirty_i = ad[prev_idx];
        for (int w = 0; w < NR_WAYS; w++) tag_i[w*TAG_W +: TAG_W] = at[prev_idx][w];
      end else begin
        tag_valid_i = '1;
        tag_dirty_i = '1;
        tag_i       = (NR_WAYS*TAG_W)'($urandom);
      end
      prev_req = tag_req_o;
      prev_inv = inv_we_o;
      prev_idx = tag_idx_o;
    end
  end

  // Write-back unit: ready WB_R cycles after valid, done WB_D cycles after accept.
  int vcnt, dcnt;
  bit outst, seen;
  always @(posedge clk_i) begin : p_wb
    #1;
    if (rst_i) begin
      wb_ready_i = 1'b0; wb_done_i = 1'b0;
      vcnt = 0; dcnt = 0; outst = 1'b0; seen = 1'b0;
    end else begin
      if (wb_ready_i && seen) begin
        outst = 1'b1;
        dcnt  = 0;
      end
      wb_ready_i = 1'b0;
      if (wb_done_i) outst = 1'b0;
      wb_done_i = 1'b0;
      if (outst) begin
        if (dcnt == WB_D) wb_done_i = 1'b1;
        dcnt++;
      end
      if (wb_valid_o && !outst) begin
        if (vcnt == WB_R) begin
          wb_ready_i = 1'b1;
          wbq.push_back(wb_addr_o);
        end
        vcnt++;
      end else begin
        vcnt = 0;
      end
      seen = wb_valid_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_array();
    for (int s = 0; s < NR_SETS; s++) begin
      av[s] = '0;
      ad[s] = '0;
      for (int w = 0; w < NR_WAYS; w++) at[s][w] = TAG_W'($urandom);
    end
  endtask

  // drop_k < 0: hold flush_i one cycle past the ack, then drop it.
  task automatic run_flush(input int g, input int drop_k);
    int dk;
    build(g, WB_R, WB_D);
    dk = (drop_k < 0) ? ack_k + 2 : drop_k;
    invq.delete();
    wbq.delete();
    acks = 0;
    tick();
    start     = cyc;
    win       = 1'b1;
    flush_i   = 1'b1;
    arr_gnt_i = (g == 0);
    for (int k = 1; k < slen + 4; k++) begin
      tick();
      if (k == g + 1) arr_gnt_i = 1'b1;
      if (k == dk) flush_i = 1'b0;
    end
    flush_i = 1'b0;
    check("ack_count", 32'(acks), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; acks = 0; start = 0; win = 1'b0;
    slen = 0; ack_k = 0;
    rst_i = 1'b1; flush_i = 1'b0; arr_gnt_i = 1'b1;
    clear_array();
    repeat (3) tick();
    check("reset_busy", 32'(busy_o),    32'd0);
    check("reset_ack",  32'(flush_ack_o), 32'd0);
    check("reset_idx",  32'(tag_idx_o), 32'd0);
    #1 rst_i = 1'b0;
    repeat (2) tick();

    // Clean cache, controller handshake with one-cycle-late drop.
    run_flush(0, -1);
    check("clean_model_ack", 32'(ack_k), 32'd14);
    check("clean_inv_count", 32'(invq.size()), 32'd4);
    if (invq.size() == 4)
      for (int i = 0; i < 4; i++) check("clean_inv_cycle", 32'(invq[i]), 32'(4 + 3 * i));
    check("clean_no_wb", 32'(wbq.size()), 32'd0);
    repeat (5) tick();

    // Set 2 fully dirty; flush_i dropped mid-walk.
    clear_array();
    av[2] = 2'b11; ad[2] = 2'b11; at[2][0] = 8'h05; at[2][1] = 8'h09;
    run_flush(0, 3);
    check("dirty_model_ack",   32'(ack_k), 32'd22);
    check("dirty_model_addr0", 32'(sched[10].addr), 32'h160);
    check("dirty_model_addr1", 32'(sched[14].addr), 32'h260);
    check("dirty_wb_count", 32'(wbq.size()), 32'd2);
    if (wbq.size() == 2) begin
      check("dirty_wb_addr0", 32'(wbq[0]), 32'h160);
      check("dirty_wb_addr1", 32'(wbq[1]), 32'h260);
    end
    if (invq.size() == 4) check("dirty_inv_set2", 32'(invq[2]), 32'd18);
    repeat (3) tick();

    // Valid-clean plus invalid-dirty: nothing to write back.
    clear_array();
    av[1] = 2'b01; ad[1] = 2'b10;
    run_flush(0, -1);
    check("mixed_model_ack", 32'(ack_k), 32'd14);
    check("mixed_no_wb", 32'(wbq.size()), 32'd0);
    check("mixed_set1_valid", 32'(av[1]), 32'd0);
    check("mixed_set1_dirty", 32'(ad[1]), 32'd0);
    repeat (3) tick();

    // Grant withheld for 5 cycles.
    clear_array();
    run_flush(5, -1);
    check("gnt_model_ack", 32'(ack_k), 32'd19);
    if (invq.size() == 4) check("gnt_inv_set0", 32'(invq[0]), 32'd9);
    repeat (3) tick();

    // Reset while waiting for write-back done in set 1.
    clear_array();
    av[1] = 2'b10; ad[1] = 2'b10; at[1][1] = 8'h03;
    build(0, WB_R, WB_D);
    invq.delete(); wbq.delete(); acks = 0;
    tick();
    start = cyc; win = 1'b1; flush_i = 1'b1; arr_gnt_i = 1'b1;
    for (int k = 1; k <= 9; k++) tick();
    check("rst_pre_busy",     32'(busy_o),      32'd1);
    check("rst_pre_wbv",      32'(wb_valid_o),  32'd0);
    check("rst_pre_accepted", 32'(wbq.size()),  32'd1);
    #2;
    win = 1'b0; rst_i = 1'b1; flush_i = 1'b0;
    #1;
    check("rst_busy",    32'(busy_o),      32'd0);
    check("rst_req",     32'(tag_req_o),   32'd0);
    check("rst_wbv",     32'(wb_valid_o),  32'd0);
    check("rst_inv",     32'(inv_we_o),    32'd0);
    check("rst_ack",     32'(flush_ack_o), 32'd0);
    check("rst_idx",     32'(tag_idx_o),   32'd0);
    check("rst_addr",    32'(wb_addr_o),   32'd0);
    check("rst_way",     32'(wb_way_o),    32'd0);
    tick();
    tick();
    #1 rst_i = 1'b0;
    repeat (3) tick();
    check("rst_no_ack", 32'(acks), 32'd0);

    // Restart after reset walks from set 0; set 1 is still dirty.
    run_flush(0, -1);
    check("restart_model_ack", 32'(ack_k), 32'd18);
    check("restart_wb_count", 32'(wbq.size()), 32'd1);
    if (wbq.size() == 1) check("restart_wb_addr", 32'(wbq[0]), 32'h0D0);
    if (invq.size() == 4) check("restart_inv_set0", 32'(invq[0]), 32'd4);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
